// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, data and shared-memory handshake signals for mem_arbiter.
// The arbiter takes the slave view; clients and the memory model take master.
interface mem_arbiter_if #(
   parameter int XLEN = 64
);
   logic                if_req;
   logic [31:0]         if_addr;
   logic                if_flush;
   logic                if_ready;
   logic                if_valid;
   logic                if_err;
   logic [XLEN-1:0]     if_rdata;

   logic                d_req;
   logic                d_we;
   logic [31:0]         d_addr;
   logic [XLEN-1:0]     d_wdata;
   logic [XLEN/8-1:0]   d_wstrb;
   logic                d_ready;
   logic                d_valid;
   logic                d_err;
   logic [XLEN-1:0]     d_rdata;

   logic                mem_req;
   logic                mem_we;
   logic [31:0]         mem_addr;
   logic [XLEN-1:0]     mem_wdata;
   logic [XLEN/8-1:0]   mem_wstrb;
   logic                mem_ack;
   logic                mem_valid;
   logic                mem_err;
   logic [XLEN-1:0]     mem_rdata;

   modport slave (
      input  if_req, if_addr, if_flush,
             d_req, d_we, d_addr, d_wdata, d_wstrb,
             mem_ack, mem_valid, mem_err, mem_rdata,
      output if_ready, if_valid, if_err, if_rdata,
             d_ready, d_valid, d_err, d_rdata,
             mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
   );

   modport master (
      output if_req, if_addr, if_flush,
             d_req, d_we, d_addr, d_wdata, d_wstrb,
             mem_ack, mem_valid, mem_err, mem_rdata,
      input  if_ready, if_valid, if_err, if_rdata,
             d_ready, d_valid, d_err, d_rdata,
             mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-client (fetch/data) arbiter onto one memory port, one transaction in flight,
// with fetch anti-starvation, per-transaction timeout and fetch-flush response dropping.
module mem_arbiter #(
   parameter int XLEN       = 64,
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic         clk,
   input  logic         reset,
   mem_arbiter_if.slave bus
);
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

   typedef struct packed {
      logic              we;
      logic [31:0]       addr;
      logic [XLEN-1:0]   wdata;
      logic [XLEN/8-1:0] wstrb;
   } req_t;

   state_e          state_q, state_d;
   req_t            req_q, req_d;
   logic            own_d_q, own_d_d;
   logic            err_q, err_d;
   logic            drop_q, drop_d;
   logic [SW-1:0]   starve_q, starve_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic [XLEN-1:0] if_rdata_q, if_rdata_d;
   logic [XLEN-1:0] d_rdata_q, d_rdata_d;

   logic            fetch_ok, grant_i, grant_d, tmo_hit, resp_load;
   logic [XLEN-1:0] resp_data;

   // Data normally wins; a fetch that has lost STARVE_MAX contested rounds wins next.
   always_comb begin
      fetch_ok = bus.if_req & ~bus.if_flush;
      grant_i  = 1'b0;
      grant_d  = 1'b0;
      if (state_q == S_IDLE && !reset) begin
         if (fetch_ok && starve_q == SW'(STARVE_MAX)) grant_i = 1'b1;
         else if (bus.d_req)                          grant_d = 1'b1;
         else if (fetch_ok)                           grant_i = 1'b1;
      end
   end

   assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));

   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      own_d_d    = own_d_q;
      err_d      = err_q;
      drop_d     = drop_q;
      starve_d   = starve_q;
      tmo_d      = tmo_q;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      resp_load  = 1'b0;
      resp_data  = '0;

      case (state_q)
         S_IDLE: begin
            drop_d = 1'b0;
            if (grant_i) begin
               req_d      = '0;
               req_d.addr = bus.if_addr;
               own_d_d    = 1'b0;
               starve_d   = '0;
               tmo_d      = '0;
               state_d    = S_ISSUE;
            end else if (grant_d) begin
               req_d.we    = bus.d_we;
               req_d.addr  = bus.d_addr;
               req_d.wdata = bus.d_wdata;
               req_d.wstrb = bus.d_wstrb;
               own_d_d     = 1'b1;
               tmo_d       = '0;
               state_d     = S_ISSUE;
               if (bus.if_req && starve_q != SW'(STARVE_MAX))
                  starve_d = starve_q + SW'(1);
            end
         end
         S_ISSUE: begin
            tmo_d = tmo_q + TW'(1);
            // A late ack loses to the timeout so mem_req drops on a fixed schedule.
            if (tmo_hit) begin
               err_d     = 1'b1;
               resp_load = 1'b1;
               state_d   = S_RESP;
            end else if (bus.mem_ack) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            tmo_d = tmo_q + TW'(1);
            if (bus.mem_valid) begin
               err_d     = bus.mem_err;
               resp_load = 1'b1;
               resp_data = req_q.we ? '0 : bus.mem_rdata;
               state_d   = S_RESP;
            end else if (tmo_hit) begin
               err_d     = 1'b1;
               resp_load = 1'b1;
               state_d   = S_RESP;
            end
         end
         S_RESP: begin
            drop_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (!own_d_q && bus.if_flush && (state_q == S_ISSUE || state_q == S_WAIT))
         drop_d = 1'b1;

      if (resp_load) begin
         if (own_d_q)     d_rdata_d  = resp_data;
         else if (!drop_d) if_rdata_d = resp_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         req_q      <= '0;
         own_d_q    <= 1'b0;
         err_q      <= 1'b0;
         drop_q     <= 1'b0;
         starve_q   <= '0;
         tmo_q      <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         own_d_q    <= own_d_d;
         err_q      <= err_d;
         drop_q     <= drop_d;
         starve_q   <= starve_d;
         tmo_q      <= tmo_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

   // A flush landing in the response cycle itself still suppresses the pulse.
   assign bus.if_ready  = grant_i;
   assign bus.d_ready   = grant_d;
   assign bus.if_valid  = (state_q == S_RESP) & ~own_d_q & ~drop_q & ~bus.if_flush;
   assign bus.if_err    = bus.if_valid & err_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.d_valid   = (state_q == S_RESP) & own_d_q;
   assign bus.d_err     = bus.d_valid & err_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.mem_req   = (state_q == S_ISSUE);
   assign bus.mem_we    = req_q.we;
   assign bus.mem_addr  = req_q.addr;
   assign bus.mem_wdata = req_q.wdata;
   assign bus.mem_wstrb = req_q.wstrb;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter XLEN, default 64, data width of all rdata/wdata buses.
REQ-002 Parameter STARVE_MAX, default 4, consecutive contested data grants before fetch is forced.
REQ-003 Parameter TIMEOUT, default 16, cycles from issue without response before the transaction errors out.
REQ-004 clk  in  1  sole clock; all state on posedge clk.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 if_req  in  1  fetch requests a read; holds it and if_addr stable until if_ready.
REQ-007 if_addr  in  32  fetch read address.
REQ-008 if_flush  in  1  fetch discards any outstanding fetch response.
REQ-009 if_ready  out  1  fetch request accepted this cycle.
REQ-010 if_valid / if_err  out  1 each  one-cycle response pulse and error flag.
REQ-011 if_rdata  out  XLEN  fetch read data, qualified by if_valid.
REQ-012 d_req, d_we  in  1 each  data request and write-enable; held stable until d_ready.
REQ-013 d_addr in 32; d_wdata in XLEN; d_wstrb in XLEN/8  data request attributes.
REQ-014 d_ready, d_valid, d_err out 1 each; d_rdata out XLEN  same meaning as the fetch equivalents.
REQ-015 mem_req, mem_we out 1; mem_addr out 32; mem_wdata out XLEN; mem_wstrb out XLEN/8  shared memory request.
REQ-016 mem_ack, mem_valid, mem_err in 1 each; mem_rdata in XLEN  request accept, response strobe, response error, read data.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT, RESP; one transaction outstanding at most.
REQ-018 IDLE: if_ready/d_ready are combinational grants, at most one high, only in IDLE; the granted request's attributes are registered; the FSM moves to ISSUE.
REQ-019 Priority: d_req wins over if_req, except when the starve counter equals STARVE_MAX, in which case if_req wins.
REQ-020 Starve counter: +1 on each data grant while if_req is high; cleared on any fetch grant; saturates at STARVE_MAX.
REQ-021 A fetch is not granted in a cycle with if_flush high.
REQ-022 Fetch grants drive mem_we=0 and mem_wstrb=0.
REQ-023 ISSUE: mem_req=1 with registered attributes held stable; on mem_ack go to WAIT.
REQ-024 WAIT: mem_req=0; on mem_valid capture mem_rdata and mem_err, then go to RESP.
REQ-025 mem_ack outside ISSUE and mem_valid outside WAIT are ignored.
REQ-026 Timeout counter clears on entry to ISSUE and increments each cycle in ISSUE or WAIT.
REQ-027 When the timeout counter reaches TIMEOUT-1 without completion, go to RESP with err=1, rdata=0, and mem_req deasserted.
REQ-028 RESP: owner's valid pulses for exactly one cycle with captured rdata/err; the FSM returns to IDLE.
REQ-029 Write responses return rdata=0.
REQ-030 Best-case latency: grant at T, mem_req at T+1, mem_ack at T+1, mem_valid at T+2, valid at T+3.
REQ-031 A new grant is possible in the cycle after RESP (T+4).
REQ-032 if_flush high in any cycle of a fetch-owned ISSUE/WAIT/RESP sets a drop flag.
REQ-033 A dropped transaction completes on memory normally, but if_valid/if_err stay 0.
REQ-034 The drop flag clears on return to IDLE.
REQ-035 if_flush has no effect on a data-owned transaction.
REQ-036 rdata outputs hold their last value outside valid; valid/err are 0 outside RESP.

Reset
REQ-037 While reset is high at posedge: FSM=IDLE; starve counter, timeout counter and drop flag = 0.
REQ-038 Reset values: all ready/valid/err outputs = 0, mem_req=0, mem_we=0; all address, data and strobe outputs = 0.
REQ-039 Reset mid-transaction abandons it with no response pulse.
REQ-040 The first grant is possible in the first cycle after reset deasserts.

Verification
REQ-041 Fetch read at 0x100, mem_ack the same cycle as mem_req, mem_valid next cycle with 0xDEAD -> if_valid=1, if_rdata=0xDEAD, if_err=0 exactly 3 cycles after if_ready.
REQ-042 if_req and d_req held high continuously with STARVE_MAX=4 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-043 Fetch granted, if_flush pulsed during WAIT, mem_valid arrives -> no if_valid; next grant in IDLE proceeds normally.
REQ-044 Data write (d_wstrb=0x0F) with no mem_ack for TIMEOUT cycles -> d_valid=1, d_err=1, d_rdata=0, mem_req low.
REQ-045 mem_valid with mem_err=1 on a data read -> d_valid=1, d_err=1.
REQ-046 reset asserted during WAIT -> all outputs 0 next cycle; no d_valid/if_valid ever produced for the abandoned request.
